div_iter: RTL

- Iterative multi-cycle divider in the EX stage, directly downstream of the divide decoder.
- Consumes div_start, div_signed and div_annul from the decoder and returns div_ready. The decoder drops div_start combinationally once div_ready rises.
- Produces a {remainder, quotient} pair for the HI/LO write path.
- One restoring quotient bit per cycle; pipeline stalls while div_start=1 and div_ready=0.

---
 rtl/div_iter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/div_iter.sv
// Iterative restoring divider for the EX stage: one quotient bit per cycle,
// signed/unsigned, divide-by-zero short path, annul and registered outputs.
module div_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_start,
    input  logic               div_signed,
    input  logic               div_annul,
    input  logic [WIDTH-1:0]   opdata_a,
    input  logic [WIDTH-1:0]   opdata_b,
    output logic [2*WIDTH-1:0] div_result,
    output logic               div_ready
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DIVZERO = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [1:0]       state;
    logic [CW-1:0]    counter;
    logic [WIDTH:0]   part_rem;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] divisor;
    logic             signed_op;
    logic             sign_a;
    logic             sign_b;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        abs_a = (div_signed && opdata_a[WIDTH-1]) ? -opdata_a : opdata_a;
        abs_b = (div_signed && opdata_b[WIDTH-1]) ? -opdata_b : opdata_b;

        // dvd_q holds the unconsumed dividend bits on top and the quotient
        // bits collected so far underneath; after WIDTH steps it is the quotient.
        shifted  = {part_rem[WIDTH-1:0], dvd_q[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial : shifted;
        quo_next = {dvd_q[WIDTH-2:0], q_bit};

        neg_q   = signed_op & (sign_a ^ sign_b);
        neg_r   = signed_op & sign_a;
        quo_fix = neg_q ? -quo_next : quo_next;
        rem_fix = neg_r ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            counter    <= '0;
            part_rem   <= '0;
            dvd_q      <= '0;
            divisor    <= '0;
            signed_op  <= 1'b0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            div_result <= '0;
            div_ready  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    div_ready  <= 1'b0;
                    div_result <= '0;
                    if (div_start && !div_annul) begin
                        signed_op <= div_signed;
                        sign_a    <= opdata_a[WIDTH-1];
                        sign_b    <= opdata_b[WIDTH-1];
                        dvd_q     <= abs_a;
                        divisor   <= abs_b;
                        part_rem  <= '0;
                        counter   <= '0;
                        state     <= (opdata_b == '0) ? S_DIVZERO : S_RUN;
                    end
                end
                S_DIVZERO: begin
                    div_result <= '0;
                    if (div_annul) begin
                        state   <= S_IDLE;
                        counter <= '0;
                    end else begin
                        state     <= S_DONE;
                        div_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (div_annul) begin
                        state      <= S_IDLE;
                        counter    <= '0;
                        div_result <= '0;
                    end else begin
                        part_rem <= rem_next;
                        dvd_q    <= quo_next;
                        counter  <= counter + 1'b1;
                        if (counter == CW'(WIDTH - 1)) begin
                            state      <= S_DONE;
                            div_ready  <= 1'b1;
                            div_result <= {rem_fix, quo_fix};
                        end
                    end
                end
                S_DONE: begin
                    if (!div_start) begin
                        state      <= S_IDLE;
                        div_ready  <= 1'b0;
                        div_result <= '0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    div_ready  <= 1'b0;
                    div_result <= '0;
                end
            endcase
        end
    end

endmodule
